// File: rtl/munoc_elastic_fifo.sv
// Elastic FIFO with sticky over/underflow error, synchronous flush and freeze.
// Define MUNOC_ELASTIC_FIFO_BYPASS_EN for same-cycle write-to-read pass-through when empty.
module munoc_elastic_fifo #(
    parameter int BW_DATA      = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                         clk,
    input  logic                         rstnn,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         wready,
    output logic                         wfull,
    output logic                         walmost_full,
    input  logic                         wrequest,
    input  logic [BW_DATA-1:0]           wdata,
    output logic                         rready,
    output logic                         rempty,
    input  logic                         rrequest,
    output logic [BW_DATA-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         error
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [PW-1:0] LAST_PTR    = PW'(DEPTH - 1);

    logic [BW_DATA-1:0] mem [DEPTH];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               wr_acc;
    logic               rd_acc;
    logic               pass_thru;
    logic               push;
    logic               pop;
    logic               err_set;

    assign wfull        = (count == FULL_LEVEL);
    assign rempty       = (count == '0);
    assign walmost_full = (count >= AFULL_LEVEL);

    // clear blocks both sides so a flush never races a transfer
    assign wready = enable & ~clear & ~wfull;

`ifdef MUNOC_ELASTIC_FIFO_BYPASS_EN
    assign rready    = enable & ~clear & (~rempty | wrequest);
    assign rdata     = rempty ? wdata : mem[rptr];
    assign pass_thru = rempty & wr_acc & rd_acc;
`else
    assign rready    = enable & ~clear & ~rempty;
    assign rdata     = mem[rptr];
    assign pass_thru = 1'b0;
`endif

    assign wr_acc  = wrequest & wready;
    assign rd_acc  = rrequest & rready;
    // a pass-through beat touches neither storage nor pointers
    assign push    = wr_acc & ~pass_thru;
    assign pop     = rd_acc & ~pass_thru;
    assign err_set = enable & ((wrequest & ~wready) | (rrequest & ~rready));

    always_ff @(posedge clk) begin
        if (rstnn && push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            error <= 1'b0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (err_set) begin
                error <= 1'b1;
            end
        end
    end

endmodule
